// File: rtl/led_pattern_sequencer.sv
// AXI4-Lite master that advances an LED pattern on each divider tick and writes it to Led_ip.
// Optional readback/compare of the LED register after each write: define LED_SEQ_READBACK_EN.
module led_pattern_sequencer #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_LED_WIDTH        = 4,
   parameter int unsigned C_TICK_DIV         = 50000000,
   parameter int unsigned C_LED_REG_ADDR     = 0
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic                              enable,
   input  logic [1:0]                        mode,
   input  logic                              err_clr,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY,
   output logic                              busy,
   output logic                              err,
   output logic [15:0]                       wr_count,
   output logic                              overrun
);

   localparam int unsigned ADDR_W = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned DATA_W = C_M_AXI_DATA_WIDTH;
   localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;
   localparam int unsigned LED_W  = C_LED_WIDTH;
   localparam int unsigned CNT_W  = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(C_TICK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_TICK = 3'd1,
      WR        = 3'd2,
      WR_RESP   = 3'd3
`ifdef LED_SEQ_READBACK_EN
      ,
      RD_ADDR   = 3'd4,
      RD_DATA   = 3'd5
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [LED_W-1:0]    pattern_q, pattern_d;
   logic [LED_W-1:0]    next_pat_c;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic                awvalid_q, awvalid_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic [15:0]         wr_count_q, wr_count_d;
   logic                overrun_q, overrun_d;
   logic                tick_c;
   logic                err_set_c;
`ifdef LED_SEQ_READBACK_EN
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
`endif

   // State and output registers
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         pattern_q  <= '0;
         awaddr_q   <= '0;
         awvalid_q  <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_count_q <= '0;
         overrun_q  <= 1'b0;
`ifdef LED_SEQ_READBACK_EN
         araddr_q   <= '0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         pattern_q  <= pattern_d;
         awaddr_q   <= awaddr_d;
         awvalid_q  <= awvalid_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         wvalid_q   <= wvalid_d;
         bready_q   <= bready_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         wr_count_q <= wr_count_d;
         overrun_q  <= overrun_d;
`ifdef LED_SEQ_READBACK_EN
         araddr_q   <= araddr_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
`endif
      end
   end

   // Next pattern for the currently selected mode; hold mode keeps the value
   always_comb begin
      next_pat_c = pattern_q;
      case (mode)
         2'd0:    next_pat_c = (pattern_q == '0) ? LED_W'(1)
                               : LED_W'((pattern_q << 1) | (pattern_q >> (LED_W - 1)));
         2'd1:    next_pat_c = pattern_q + LED_W'(1);
         2'd2:    next_pat_c = (pattern_q == '1) ? '0 : '1;
         default: next_pat_c = pattern_q;
      endcase
   end

   // Tick divider, transaction sequencing and status
   always_comb begin
      state_d    = state_q;
      pattern_d  = pattern_q;
      awaddr_d   = awaddr_q;
      awvalid_d  = awvalid_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      wvalid_d   = wvalid_q;
      bready_d   = bready_q;
      wr_count_d = wr_count_q;
      err_set_c  = 1'b0;
`ifdef LED_SEQ_READBACK_EN
      araddr_d   = araddr_q;
      arvalid_d  = arvalid_q;
      rready_d   = rready_q;
`endif

      tick_c     = enable && (tick_cnt_q == TICK_LAST);
      tick_cnt_d = (!enable || tick_c) ? '0 : tick_cnt_q + CNT_W'(1);
      overrun_d  = tick_c && (state_q != WAIT_TICK);

      case (state_q)
         IDLE: begin
            if (enable) state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (tick_c && (mode != 2'd3)) begin
               pattern_d = next_pat_c;
               wdata_d   = DATA_W'(next_pat_c);
               awaddr_d  = ADDR_W'(C_LED_REG_ADDR);
               wstrb_d   = '1;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = WR;
            end
         end
         WR: begin
            // Each channel drops on its own handshake; leave once both are done
            awvalid_d = awvalid_q && !M_AXI_AWREADY;
            wvalid_d  = wvalid_q && !M_AXI_WREADY;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (M_AXI_BVALID) begin
               bready_d   = 1'b0;
               wr_count_d = wr_count_q + 16'd1;
               err_set_c  = (M_AXI_BRESP != 2'b00);
`ifdef LED_SEQ_READBACK_EN
               araddr_d   = ADDR_W'(C_LED_REG_ADDR);
               arvalid_d  = 1'b1;
               state_d    = RD_ADDR;
`else
               state_d    = enable ? WAIT_TICK : IDLE;
`endif
            end
         end
`ifdef LED_SEQ_READBACK_EN
         RD_ADDR: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (M_AXI_RVALID) begin
               rready_d  = 1'b0;
               err_set_c = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA[LED_W-1:0] != pattern_q);
               state_d   = enable ? WAIT_TICK : IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      err_d  = err_set_c ? 1'b1 : (err_clr ? 1'b0 : err_q);
      busy_d = (state_d != IDLE) && (state_d != WAIT_TICK);
   end

   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign busy          = busy_q;
   assign err           = err_q;
   assign wr_count      = wr_count_q;
   assign overrun       = overrun_q;

`ifdef LED_SEQ_READBACK_EN
   logic unused_c;
   assign unused_c      = ^M_AXI_RDATA;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;
`else
   // Read channel tied off when readback is not built
   logic unused_c;
   assign unused_c      = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
   assign M_AXI_ARADDR  = '0;
   assign M_AXI_ARVALID = 1'b0;
   assign M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a small AXI4-Lite slave model.
// Slave raises READY one cycle after VALID (plus a programmable delay) and BVALID after both handshakes.
module tb_led_pattern_sequencer;

`ifdef LED_SEQ_READBACK_EN
   localparam int unsigned TB_DIV = 8;
   localparam int unsigned BPW    = 6;
`else
   localparam int unsigned TB_DIV = 4;
   localparam int unsigned BPW    = 3;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  mode;
   logic        err_clr;
   logic [3:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        busy;
   logic        err;
   logic [15:0] wr_count;
   logic        overrun;

   int          checks = 0;
   int          errors = 0;

   int          aw_delay = 0;
   int          w_delay  = 0;
   logic [1:0]  bresp_cfg = 2'b00;
   logic [3:0]  r_xor = 4'h0;

   led_pattern_sequencer #(
      .C_M_AXI_ADDR_WIDTH (4),
      .C_M_AXI_DATA_WIDTH (32),
      .C_LED_WIDTH        (4),
      .C_TICK_DIV         (TB_DIV),
      .C_LED_REG_ADDR     (0)
   ) dut (
      .ACLK          (clk),
      .ARESETN       (rst_n),
      .enable        (enable),
      .mode          (mode),
      .err_clr       (err_clr),
      .M_AXI_AWADDR  (awaddr),
      .M_AXI_AWPROT  (awprot),
      .M_AXI_AWVALID (awvalid),
      .M_AXI_AWREADY (awready),
      .M_AXI_WDATA   (wdata),
      .M_AXI_WSTRB   (wstrb),
      .M_AXI_WVALID  (wvalid),
      .M_AXI_WREADY  (wready),
      .M_AXI_BRESP   (bresp),
      .M_AXI_BVALID  (bvalid),
      .M_AXI_BREADY  (bready),
      .M_AXI_ARADDR  (araddr),
      .M_AXI_ARPROT  (arprot),
      .M_AXI_ARVALID (arvalid),
      .M_AXI_ARREADY (arready),
      .M_AXI_RDATA   (rdata),
      .M_AXI_RRESP   (rresp),
      .M_AXI_RVALID  (rvalid),
      .M_AXI_RREADY  (rready),
      .busy          (busy),
      .err           (err),
      .wr_count      (wr_count),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   // Slave model
   int   aw_cnt, w_cnt;
   logic aw_seen, w_seen;
   logic [3:0] led_reg;
   logic aw_hs, w_hs;
   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
         arready <= 1'b0; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
         aw_cnt <= 0; w_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0; led_reg <= 4'h0;
      end else begin
         if (awready) awready <= 1'b0;
         else if (awvalid) begin
            if (aw_cnt >= aw_delay) begin awready <= 1'b1; aw_cnt <= 0; end
            else aw_cnt <= aw_cnt + 1;
         end
         if (wready) wready <= 1'b0;
         else if (wvalid) begin
            if (w_cnt >= w_delay) begin wready <= 1'b1; w_cnt <= 0; end
            else w_cnt <= w_cnt + 1;
         end
         if (w_hs) led_reg <= wdata[3:0];
         if (bvalid) begin
            if (bready) bvalid <= 1'b0;
         end else if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
            bvalid <= 1'b1; bresp <= bresp_cfg; aw_seen <= 1'b0; w_seen <= 1'b0;
         end else begin
            if (aw_hs) aw_seen <= 1'b1;
            if (w_hs)  w_seen  <= 1'b1;
         end
         if (arready) arready <= 1'b0;
         else if (arvalid) arready <= 1'b1;
         if (rvalid) begin
            if (rready) rvalid <= 1'b0;
         end else if (arvalid && arready) begin
            rvalid <= 1'b1; rdata <= {28'h0, led_reg ^ r_xor};
         end
      end
   end

   // Transaction log and activity monitors
   int          cyc = 0;
   int          aw_n = 0;
   int          b_n = 0;
   logic [31:0] wq[$];
   int          wc[$];
   int          busy_cyc = 0;
   int          ovr_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (aw_hs) aw_n <= aw_n + 1;
      if (w_hs) begin wq.push_back(wdata); wc.push_back(cyc); end
      if (bvalid && bready) b_n <= b_n + 1;
   end

   always @(negedge clk) begin
      if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
      if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_wr(input string tag, input logic [15:0] target, input int budget);
      int k = 0;
      while (wr_count !== target && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(wr_count), 32'(target));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base_w, base_b, base_aw, busy0, ovr0, nw, k;
      logic [31:0] exp_walk [5];
      exp_walk = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
      rst_n = 1'b0; enable = 1'b0; mode = 2'd0; err_clr = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_awvalid", 32'(awvalid), 32'h0);
      chk("rst_wvalid", 32'(wvalid), 32'h0);
      chk("rst_bready", 32'(bready), 32'h0);
      chk("rst_arvalid", 32'(arvalid), 32'h0);
      chk("rst_rready", 32'(rready), 32'h0);
      chk("rst_awaddr", 32'(awaddr), 32'h0);
      chk("rst_araddr", 32'(araddr), 32'h0);
      chk("rst_wdata", wdata, 32'h0);
      chk("rst_wstrb", 32'(wstrb), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_wr_count", 32'(wr_count), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);

      // Walking one: first write one divider period after enable
      rst_n = 1'b1;
      @(negedge clk);
      base_w = wq.size(); base_b = b_n; busy0 = busy_cyc; ovr0 = ovr_cnt;
      mode = 2'd0; enable = 1'b1;
      repeat (TB_DIV - 1) @(posedge clk);
      @(negedge clk);
      chk("walk_no_early", 32'(awvalid), 32'h0);
      @(negedge clk);
      chk("walk_awvalid", 32'(awvalid), 32'h1);
      chk("walk_wvalid", 32'(wvalid), 32'h1);
      chk("walk_wdata0", wdata, 32'h1);
      chk("walk_awaddr", 32'(awaddr), 32'h0);
      chk("walk_awprot", 32'(awprot), 32'h0);
      chk("walk_wstrb", 32'(wstrb), 32'hF);
      chk("walk_busy", 32'(busy), 32'h1);
      wait_wr("walk_wr_count", 16'd5, 100 * TB_DIV);
      enable = 1'b0;
      repeat (12) @(negedge clk);
      chk("walk_nwrites", 32'(wq.size() - base_w), 32'd5);
      chk("walk_nresp", 32'(b_n - base_b), 32'd5);
      chk("walk_busy_cycles", 32'(busy_cyc - busy0), 32'(5 * BPW));
      chk("walk_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);
      chk("walk_idle_busy", 32'(busy), 32'h0);
      if (wq.size() >= base_w + 5) begin
         for (int i = 0; i < 5; i++)
            chk($sformatf("walk_data[%0d]", i), wq[base_w + i], exp_walk[i]);
         for (int i = 0; i < 4; i++)
            chk($sformatf("walk_gap[%0d]", i), 32'(wc[base_w + i + 1] - wc[base_w + i]), 32'(TB_DIV));
      end

      // Binary count from reset pattern, then blink, then hold
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      base_w = wq.size();
      mode = 2'd1; enable = 1'b1;
      wait_wr("count_wr_count", 16'd17, 40 * TB_DIV);
      mode = 2'd2;
      wait_wr("blink_wr_count", 16'd21, 20 * TB_DIV);
      mode = 2'd3;
      nw = wq.size();
      repeat (5 * TB_DIV) @(negedge clk);
      chk("hold_wr_count", 32'(wr_count), 32'd21);
      chk("hold_no_write", 32'(wq.size()), 32'(nw));
      enable = 1'b0;
      repeat (12) @(negedge clk);
      chk("count_nwrites", 32'(wq.size() - base_w), 32'd21);
      if (wq.size() >= base_w + 21) begin
         for (int i = 0; i < 17; i++)
            chk($sformatf("count_data[%0d]", i), wq[base_w + i], 32'((i + 1) % 16));
         for (int i = 0; i < 4; i++)
            chk($sformatf("blink_data[%0d]", i), wq[base_w + 17 + i], (i % 2 == 0) ? 32'hF : 32'h0);
      end

      // AWREADY stalled after WREADY: stable payload, one B, one dropped tick
      aw_delay = int'(TB_DIV) - 1;
      mode = 2'd1;
      base_w = wq.size(); base_b = b_n; base_aw = aw_n; ovr0 = ovr_cnt;
      enable = 1'b1;
      repeat (TB_DIV) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i <= aw_delay + 1; i++) begin
         chk($sformatf("stall_awvalid[%0d]", i), 32'(awvalid), 32'h1);
         chk($sformatf("stall_awaddr[%0d]", i), 32'(awaddr), 32'h0);
         chk($sformatf("stall_wdata[%0d]", i), wdata, 32'h1);
         chk($sformatf("stall_wvalid[%0d]", i), 32'(wvalid), (i < 2) ? 32'h1 : 32'h0);
         @(negedge clk);
      end
      wait_wr("stall_wr_count", 16'd22, 20 * TB_DIV);
      enable = 1'b0;
      repeat (12) @(negedge clk);
      chk("stall_nwrites", 32'(wq.size() - base_w), 32'd1);
      chk("stall_naw", 32'(aw_n - base_aw), 32'd1);
      chk("stall_nresp", 32'(b_n - base_b), 32'd1);
      chk("stall_overrun", 32'(ovr_cnt - ovr0), 32'd1);
      aw_delay = 0;

      // SLVERR sets sticky err; err_clr clears; set wins over clear
      bresp_cfg = 2'b10;
      enable = 1'b1;
      wait_wr("slverr_wr_count", 16'd23, 20 * TB_DIV);
      chk("slverr_set", 32'(err), 32'h1);
      bresp_cfg = 2'b00;
      wait_wr("slverr_more", 16'd25, 20 * TB_DIV);
      enable = 1'b0;
      chk("slverr_sticky", 32'(err), 32'h1);
      repeat (12) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr", 32'(err), 32'h0);
      bresp_cfg = 2'b10;
      err_clr = 1'b1;
      enable = 1'b1;
      wait_wr("setwins_wr_count", 16'd26, 20 * TB_DIV);
      enable = 1'b0;
      chk("set_wins", 32'(err), 32'h1);
      @(negedge clk);
      chk("clr_after_set", 32'(err), 32'h0);
      err_clr = 1'b0;
      bresp_cfg = 2'b00;
      repeat (12) @(negedge clk);

      // Reset while WVALID high
      enable = 1'b1;
      k = 0;
      while (wvalid !== 1'b1 && k < 10 * int'(TB_DIV)) begin
         @(negedge clk);
         k++;
      end
      chk("rst_wait_wvalid", 32'(wvalid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midrst_awvalid", 32'(awvalid), 32'h0);
      chk("midrst_wvalid", 32'(wvalid), 32'h0);
      chk("midrst_wdata", wdata, 32'h0);
      chk("midrst_wstrb", 32'(wstrb), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_wr_count", 32'(wr_count), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (TB_DIV - 1) @(posedge clk);
      @(negedge clk);
      chk("postrst_no_write", 32'(awvalid), 32'h0);
      @(negedge clk);
      chk("postrst_awvalid", 32'(awvalid), 32'h1);
      chk("postrst_wdata", wdata, 32'h1);
      wait_wr("postrst_wr_count", 16'd1, 20 * TB_DIV);
      enable = 1'b0;
      repeat (12) @(negedge clk);

`ifdef LED_SEQ_READBACK_EN
      // Readback mismatch flags err; a faithful slave keeps it clear
      r_xor = 4'h1;
      enable = 1'b1;
      wait_wr("rb_bad_wr_count", 16'd2, 20 * TB_DIV);
      enable = 1'b0;
      repeat (12) @(negedge clk);
      chk("rb_mismatch", 32'(err), 32'h1);
      r_xor = 4'h0;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("rb_err_clr", 32'(err), 32'h0);
      enable = 1'b1;
      wait_wr("rb_good_wr_count", 16'd10, 100 * TB_DIV);
      enable = 1'b0;
      repeat (12) @(negedge clk);
      chk("rb_clean", 32'(err), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

AXI4-Lite master that drives LED patterns into the Led_ip slave register file without processor involvement. A programmable tick divider times each update. On every tick the sequencer computes the next pattern for the selected mode and writes it to the LED data register over AXI4-Lite. It sits between the board-level mode/enable controls and the S00_AXI port of Led_ip_v1_0, in the same ACLK domain.

## Interface
- C_M_AXI_ADDR_WIDTH, 4, address width; matches the Led_ip 4-register map.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_LED_WIDTH, 4, pattern width in bits (1..32); zero-extended onto WDATA.
- C_TICK_DIV, 50000000, ACLK cycles per pattern update (≥2).
- C_LED_REG_ADDR, 0, byte address of the LED data register.
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- enable  in  1  runs the tick divider and sequencing while high.
- mode  in  2  0 walking-one, 1 binary count, 2 blink all, 3 hold.
- err_clr  in  1  single-cycle pulse; clears err.
- M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR/3/1; M_AXI_AWREADY  in  1
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1; M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1
- M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR/3/1; M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32; M_AXI_RRESP  in  2; M_AXI_RVALID  in  1; M_AXI_RREADY  out  1
- busy  out  1  high in any state other than IDLE or WAIT_TICK.
- err  out  1  sticky flag: bad response or readback mismatch.
- wr_count  out  16  number of completed writes; wraps at 0xFFFF→0.
- overrun  out  1  one-cycle pulse when a tick is dropped because the sequencer is busy.

## Operation
- States and transitions:
  - IDLE: waits for enable.
  - WAIT_TICK: counts ticks.
  - WR: AW and W issued together.
  - WR_RESP: waits for the write response.
  - RD_ADDR and RD_DATA: readback, only when LED_SEQ_READBACK_EN is defined.
- IDLE→WAIT_TICK when enable=1.
- WAIT_TICK→IDLE when enable=0; the tick counter clears to 0.
- Tick counter runs 0..C_TICK_DIV-1 while enable=1. The terminal count is the tick.
- On a tick in WAIT_TICK with mode≠3: the next pattern is computed, latched into WDATA, and the FSM enters WR. With mode=3 a tick causes no action.
- Pattern rules (pattern register resets to 0):
  - mode 0: if pattern==0, load 1; otherwise rotate left within C_LED_WIDTH (MSB wraps to bit 0).
  - mode 1: pattern+1 modulo 2^C_LED_WIDTH.
  - mode 2: if pattern==all-ones, load 0; otherwise load all-ones.
- WR: AWVALID and WVALID rise together.
  - Each drops independently on its own handshake.
  - WR→WR_RESP once both have handshaked, in either order or in the same cycle.
- AWADDR=C_LED_REG_ADDR, AWPROT=0, WSTRB=4'hF. Address and data are held stable while VALID is high.
- WR_RESP: BREADY=1. On BVALID: wr_count increments, and err is set if BRESP≠OKAY.
  - The FSM then goes to RD_ADDR if readback is enabled, otherwise to WAIT_TICK.
- The tick counter keeps running during WR/WR_RESP/RD.
  - A tick that occurs outside WAIT_TICK produces an overrun pulse and is dropped; the pattern does not advance.
- Clearing enable mid-transaction: the current transaction completes, then the FSM goes to IDLE. VALID is never withdrawn before its handshake.
- Mode changes take effect at the next tick. The pattern is not reset on a mode change.
- err_clr and an error event in the same cycle: set wins.

## Timing
- Reset values: all VALID=0, BREADY=0, RREADY=0, AWADDR=ARADDR=0, WDATA=0, WSTRB=0, busy=0, err=0, wr_count=0, overrun=0; FSM in IDLE.
- Latency from tick to AWVALID/WVALID high: 1 cycle (registered).
- With AWREADY, WREADY and BVALID returned in zero wait states, a write completes in 3 cycles and busy is high for 3 cycles.
- Outputs are registered; no combinational path exists from any input to any VALID or READY output.

## Configuration
- LED_SEQ_READBACK_EN defined: after each write the sequencer reads C_LED_REG_ADDR.
  - RD_ADDR: ARVALID=1 until ARREADY.
  - RD_DATA: RREADY=1 until RVALID.
  - err is set if RRESP≠OKAY or RDATA[C_LED_WIDTH-1:0]≠pattern.
  - The FSM then returns to WAIT_TICK.
- LED_SEQ_READBACK_EN undefined: the read channel is unused. ARVALID=0, RREADY=0, ARADDR=0 and ARPROT=0 are tied off, and the RD states are absent.

## Test plan
- C_TICK_DIV=4, mode 0, zero-wait slave: writes of 0x1, 0x2, 0x4, 0x8, 0x1 are issued every 4 cycles, and wr_count reaches 5.
- mode 1 with C_LED_WIDTH=4, 17 ticks: WDATA sequence 0x1..0xF, 0x0, 0x1; mode 2 thereafter: 0xF, 0x0 alternating.
- Slave holds AWREADY low 3 cycles after WREADY: AWADDR and WDATA stay stable, there is exactly one B handshake, and a tick during the stall pulses overrun.
- Slave returns BRESP=SLVERR: err=1 and stays set through later writes; err_clr clears it.
- Readback enabled, slave returns RDATA=pattern^1: err=1. With a correct slave model there are 8 cycles of updates with err=0.
- ARESETN asserted low while WVALID is high: every output returns to its reset value immediately. After release there is no write until the first tick after enable.
